tx_serializer: RTL and testbench

Parametrised UART transmit engine for the TramelBlaze 16-bit processor system, sitting between the processor's write port and the TXD pin. It takes a data word from a `WRITE_STROBE`-qualified port write and serialises it as start, data (LSB first), optional parity, and one or two stop bits at a programmable bit period. A one-deep holding register allows back-to-back frames with no idle gap. A per-frame `TX_DONE` pulse is suitable for direct connection to the processor `INTERRUPT`.

---
 rtl/tx_serializer.sv | 181 ++++++++++++++++++
 tb/tb_tx_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_serializer.sv
// UART transmit engine: one-deep holding register feeding a start/data/parity/stop serializer.
// Optional parity support is compiled in with `define TX_PARITY_EN.
module tx_serializer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DIV_W-1:0]  BAUD_DIV,
    input  logic              STOP2,
`ifdef TX_PARITY_EN
    input  logic              PARITY_ON,
    input  logic              PARITY_ODD,
`endif
    input  logic              LOAD,
    input  logic [DATA_W-1:0] DIN,
    output logic              TXD,
    output logic              TX_RDY,
    output logic              BUSY,
    output logic              TX_DONE,
    output logic              OVERRUN
);

    localparam int unsigned CntW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef TX_PARITY_EN
        StParity,
`endif
        StStop1,
        StStop2
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] shift_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  baud_cnt_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic              stop2_q;
`ifdef TX_PARITY_EN
    logic              par_on_q;
    logic              par_bit_q;
`endif
    logic              txd_q;
    logic              tx_rdy_q;
    logic              busy_q;
    logic              tx_done_q;
    logic              overrun_q;

    logic bit_end;
    logic last_stop;
    logic frame_end;
    logic xfer;

    always_comb begin
        bit_end   = (baud_cnt_q == div_q);
        last_stop = (state_q == StStop2) || ((state_q == StStop1) && !stop2_q);
        frame_end = last_stop && bit_end;
        // A full holding register is moved to the shifter from IDLE or straight out of
        // the final stop bit, so back-to-back frames have no idle gap.
        xfer      = !tx_rdy_q && ((state_q == StIdle) || frame_end);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            shift_q    <= '0;
            div_q      <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop2_q    <= 1'b0;
`ifdef TX_PARITY_EN
            par_on_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
            txd_q      <= 1'b1;
            tx_rdy_q   <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            tx_done_q <= frame_end;

            if (LOAD) begin
                if (tx_rdy_q) begin
                    hold_q   <= DIN;
                    tx_rdy_q <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            if (xfer) begin
                shift_q    <= hold_q;
                tx_rdy_q   <= 1'b1;
                div_q      <= BAUD_DIV;
                stop2_q    <= STOP2;
`ifdef TX_PARITY_EN
                par_on_q   <= PARITY_ON;
                par_bit_q  <= (^hold_q) ^ PARITY_ODD;
`endif
                baud_cnt_q <= '0;
                bit_cnt_q  <= '0;
                state_q    <= StStart;
                txd_q      <= 1'b0;
                busy_q     <= 1'b1;
            end else if (state_q != StIdle) begin
                if (!bit_end) begin
                    baud_cnt_q <= baud_cnt_q + DIV_W'(1);
                end else begin
                    baud_cnt_q <= '0;
                    unique case (state_q)
                        StStart: begin
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= '0;
                            state_q   <= StData;
                        end
                        StData: begin
                            if (bit_cnt_q == CntW'(DATA_W - 1)) begin
`ifdef TX_PARITY_EN
                                if (par_on_q) begin
                                    txd_q   <= par_bit_q;
                                    state_q <= StParity;
                                end else begin
                                    txd_q   <= 1'b1;
                                    state_q <= StStop1;
                                end
`else
                                txd_q   <= 1'b1;
                                state_q <= StStop1;
`endif
                            end else begin
                                txd_q     <= shift_q[0];
                                shift_q   <= shift_q >> 1;
                                bit_cnt_q <= bit_cnt_q + CntW'(1);
                            end
                        end
`ifdef TX_PARITY_EN
                        StParity: begin
                            txd_q   <= 1'b1;
                            state_q <= StStop1;
                        end
`endif
                        StStop1: begin
                            txd_q <= 1'b1;
                            if (stop2_q) begin
                                state_q <= StStop2;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end
                        StStop2: begin
                            txd_q   <= 1'b1;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                        default: begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            txd_q   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign TXD     = txd_q;
    assign TX_RDY  = tx_rdy_q;
    assign BUSY    = busy_q;
    assign TX_DONE = tx_done_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: loaded words are queued as expected frames and checked bit by bit
// as the serial line produces them.
module tb_tx_serializer;

    logic        CLK;
    logic        RESET_N;
    logic [15:0] baud_div;
    logic        stop2;
`ifdef TX_PARITY_EN
    logic        parity_on;
    logic        parity_odd;
`endif
    logic        LOAD;
    logic [7:0]  DIN;
    logic        TXD;
    logic        TX_RDY;
    logic        BUSY;
    logic        TX_DONE;
    logic        OVERRUN;

    typedef struct {
        logic [7:0] data;
        bit         par_on;
        bit         par_odd;
        bit         stop2;
        int         div;
    } frame_t;

    frame_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    tx_serializer #(
        .DATA_W(8),
        .DIV_W (16)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .BAUD_DIV  (baud_div),
        .STOP2     (stop2),
`ifdef TX_PARITY_EN
        .PARITY_ON (parity_on),
        .PARITY_ODD(parity_odd),
`endif
        .LOAD      (LOAD),
        .DIN       (DIN),
        .TXD       (TXD),
        .TX_RDY    (TX_RDY),
        .BUSY      (BUSY),
        .TX_DONE   (TX_DONE),
        .OVERRUN   (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse LOAD for one clock; returns at the negedge after the sampling edge.
    task automatic load_word(input logic [7:0] d, input bit push);
        frame_t f;
        DIN  = d;
        LOAD = 1'b1;
        if (push) begin
            f.data    = d;
            f.stop2   = stop2;
            f.div     = int'(baud_div);
`ifdef TX_PARITY_EN
            f.par_on  = parity_on;
            f.par_odd = parity_odd;
`else
            f.par_on  = 1'b0;
            f.par_odd = 1'b0;
`endif
            exp_q.push_back(f);
        end
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    // Load from idle and check the LOAD-to-line timing; returns on the first start-bit clock.
    task automatic load_from_idle(input logic [7:0] d, input string tag);
        load_word(d, 1'b1);
        check_eq({tag, "_rdy_n"}, TX_RDY, 1'b0);
        check_eq({tag, "_txd_n"}, TXD, 1'b1);
        @(negedge CLK);
        check_eq({tag, "_rdy_n1"}, TX_RDY, 1'b1);
        check_eq({tag, "_txd_n1"}, TXD, 1'b0);
    endtask

    // Receive one frame, compare against the scoreboard head; ends on the TX_DONE cycle.
    task automatic rx_frame(input int exp_gap);
        frame_t f;
        logic   bits[0:12];
        int     n;
        int     waited;
        waited = 0;
        while (TXD !== 1'b0 && waited < 2000) begin
            @(negedge CLK);
            waited++;
        end
        if (TXD !== 1'b0) begin
            check_eq("start_timeout", TXD, 1'b0);
            return;
        end
        if (exp_gap >= 0) check_eq("gap", waited, exp_gap);
        if (exp_q.size() == 0) begin
            check_eq("unexpected_frame", 1, 0);
            return;
        end
        f = exp_q.pop_front();
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = f.data[i];
        n = 9;
        if (f.par_on) begin
            bits[n] = (^f.data) ^ f.par_odd;
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (f.stop2) begin
            bits[n] = 1'b1;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c <= f.div; c++) begin
                check_eq($sformatf("txd_%02h_b%0d_c%0d", f.data, b, c), TXD, bits[b]);
                if (c == 0) check_eq($sformatf("busy_%02h_b%0d", f.data, b), BUSY, 1'b1);
                if (b == n - 1 && c == f.div) check_eq("done_early", TX_DONE, 1'b0);
                @(negedge CLK);
            end
        end
        check_eq($sformatf("tx_done_%02h", f.data), TX_DONE, 1'b1);
    endtask

    initial begin
        int bad;
        RESET_N  = 1'b0;
        LOAD     = 1'b0;
        DIN      = '0;
        baud_div = 16'd3;
        stop2    = 1'b0;
`ifdef TX_PARITY_EN
        parity_on  = 1'b0;
        parity_odd = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        check_eq("rst_txd", TXD, 1'b1);
        check_eq("rst_rdy", TX_RDY, 1'b1);
        check_eq("rst_busy", BUSY, 1'b0);
        check_eq("rst_done", TX_DONE, 1'b0);
        check_eq("rst_ovr", OVERRUN, 1'b0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // 1: 0xA5, one stop bit, no parity
        load_from_idle(8'hA5, "t1");
        rx_frame(0);
        check_eq("t1_busy_after", BUSY, 1'b0);
        @(negedge CLK);
        check_eq("t1_done_1cyc", TX_DONE, 1'b0);

`ifdef TX_PARITY_EN
        // 2: parity even then odd
        parity_on  = 1'b1;
        parity_odd = 1'b0;
        load_from_idle(8'hA5, "t2e");
        rx_frame(0);
        parity_odd = 1'b1;
        repeat (2) @(negedge CLK);
        load_from_idle(8'hA5, "t2o");
        rx_frame(0);
        parity_on  = 1'b0;
        parity_odd = 1'b0;
        repeat (2) @(negedge CLK);
`endif

        // 3: back-to-back frames plus an overrun load that must be dropped
        load_from_idle(8'h3C, "t3");
        fork
            begin
                rx_frame(0);
                rx_frame(0);
            end
            begin
                load_word(8'h81, 1'b1);
                repeat (5) @(negedge CLK);
                load_word(8'h99, 1'b0);
                check_eq("t3_overrun", OVERRUN, 1'b1);
            end
        join
        check_eq("t3_busy_after", BUSY, 1'b0);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (TXD !== 1'b1 || BUSY !== 1'b0) bad++;
        end
        check_eq("t3_no_third", bad, 0);
        check_eq("t3_queue_empty", exp_q.size(), 0);

        // 4: two stop bits, divisor changed mid-frame
        stop2 = 1'b1;
        load_from_idle(8'hA5, "t4a");
        fork
            rx_frame(0);
            begin
                repeat (10) @(negedge CLK);
                baud_div = 16'd7;
                stop2    = 1'b0;
            end
        join
        repeat (2) @(negedge CLK);
        load_from_idle(8'h5A, "t4b");
        rx_frame(0);
        check_eq("t4_busy_after", BUSY, 1'b0);
        baud_div = 16'd3;
        repeat (2) @(negedge CLK);

        // 5: reset during data bit 3
        check_eq("t5_ovr_sticky", OVERRUN, 1'b1);
        load_word(8'hC3, 1'b0);
        @(negedge CLK);
        repeat (17) @(negedge CLK);
        check_eq("t5_pre_txd", TXD, 1'b0);
        check_eq("t5_pre_busy", BUSY, 1'b1);
        RESET_N = 1'b0;
        @(negedge CLK);
        check_eq("t5_txd", TXD, 1'b1);
        check_eq("t5_rdy", TX_RDY, 1'b1);
        check_eq("t5_busy", BUSY, 1'b0);
        check_eq("t5_ovr", OVERRUN, 1'b0);
        check_eq("t5_done", TX_DONE, 1'b0);
        RESET_N = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (TXD !== 1'b1 || TX_DONE !== 1'b0) bad++;
        end
        check_eq("t5_quiet", bad, 0);
        load_from_idle(8'h96, "t5");
        rx_frame(0);

        // 6: one-clock bit period
        baud_div = 16'd0;
        repeat (2) @(negedge CLK);
        load_from_idle(8'hFF, "t6");
        rx_frame(0);
        check_eq("t6_busy_after", BUSY, 1'b0);
        check_eq("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
